multi_mode_shift_reg: RTL and testbench

- Parametrised successor of the team's single-bit D flip-flop: a WIDTH-bit register with the same asynchronous reset.
- Adds synchronous clear, clock enable, parallel load, shift/rotate modes and serial I/O.
- Adds a counted "burst" shift engine with a busy/done handshake.
- Used as the generic state/serialiser register in datapaths (SPI-style serialisers, barrel-step multipliers, LFSR seeds).

---
 rtl/multi_mode_shift_reg.sv | 117 +++++++++++
 tb/tb_multi_mode_shift_reg.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_mode_shift_reg.sv
// WIDTH-bit register with parallel load, shift/rotate modes, serial I/O and a
// counted burst engine that runs the latched mode for a programmed step count.
module multi_mode_shift_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               CNT_W   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROTL = 3'b100;
  localparam logic [2:0] MODE_ROTR = 3'b101;
  localparam logic [2:0] MODE_ASHR = 3'b110;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] ld_q, ld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [2:0]       mode_q, mode_d;

  function automatic logic [WIDTH-1:0] step_fn(input logic [2:0] op,
                                               input logic [WIDTH-1:0] cur,
                                               input logic [WIDTH-1:0] dat,
                                               input logic sl, input logic sr);
    logic [WIDTH-1:0] nxt;
    nxt = cur;
    case (op)
      MODE_LOAD: nxt = dat;
      MODE_SHL:  nxt = {cur[WIDTH-2:0], sr};
      MODE_SHR:  nxt = {sl, cur[WIDTH-1:1]};
      MODE_ROTL: nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
      MODE_ROTR: nxt = {cur[0], cur[WIDTH-1:1]};
      MODE_ASHR: nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
      default:   nxt = cur;
    endcase
    return nxt;
  endfunction

  // A load burst reuses the data captured at acceptance, since live d is ignored
  always_comb begin
    q_d    = q_q;
    ld_d   = ld_q;
    busy_d = busy_q;
    done_d = 1'b0;
    rem_d  = rem_q;
    mode_d = mode_q;
    if (clr) begin
      q_d    = RST_VAL;
      busy_d = 1'b0;
      rem_d  = '0;
    end else if (busy_q) begin
      if (en) begin
        q_d   = step_fn(mode_q, q_q, ld_q, sin_l, sin_r);
        rem_d = rem_q - 1'b1;
        if (rem_q == CNT_W'(1)) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
    end else if (start) begin
      if (count != '0) begin
        mode_d = mode;
        rem_d  = count;
        ld_d   = d;
        busy_d = 1'b1;
      end else begin
        done_d = 1'b1;
      end
    end else if (en) begin
      q_d = step_fn(mode, q_q, d, sin_l, sin_r);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= RST_VAL;
      ld_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rem_q  <= '0;
      mode_q <= MODE_HOLD;
    end else begin
      q_q    <= q_d;
      ld_q   <= ld_d;
      busy_q <= busy_d;
      done_q <= done_d;
      rem_q  <= rem_d;
      mode_q <= mode_d;
    end
  end

  assign q      = q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_multi_mode_shift_reg.sv
// Scoreboard bench: driver pushes expected post-edge state from an arithmetic
// model, a monitor pops and compares after every clock edge.
module tb_multi_mode_shift_reg;
  localparam int W = 8;
  localparam int CW = 4;

  logic clk = 0, rst = 1, clr = 0, en = 0, sin_l = 0, sin_r = 0, start = 0;
  logic [2:0] mode = 0;
  logic [W-1:0] d = 0;
  logic [CW-1:0] count = 0;
  logic [W-1:0] q;
  logic sout_l, sout_r, busy, done;

  multi_mode_shift_reg #(.WIDTH(W), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .mode(mode), .d(d),
    .sin_l(sin_l), .sin_r(sin_r), .start(start), .count(count),
    .q(q), .sout_l(sout_l), .sout_r(sout_r), .busy(busy), .done(done));

  always #5 clk = ~clk;

  typedef struct { int q; bit busy; bit done; } exp_t;
  exp_t sb_q[$];

  int checks = 0, errors = 0, done_seen = 0;
  bit mon_en = 0;

  // reference state: value, outstanding burst steps, burst operation and its data
  int m_q = 0, m_left = 0, m_op = 0, m_data = 0;
  bit m_done = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int apply(input int op, input int v, input int dd, input int sl, input int sr);
    case (op)
      1: return dd;
      2: return ((v * 2) + sr) % 256;
      3: return (v / 2) + sl * 128;
      4: return ((v * 2) % 256) + (v / 128);
      5: return (v / 2) + (v % 2) * 128;
      6: return (v / 2) + (v / 128) * 128;
      default: return v;
    endcase
  endfunction

  task automatic model_step();
    bit nd = 0;
    if (clr) begin
      m_q = 0; m_left = 0;
    end else if (m_left > 0) begin
      if (en) begin
        m_q = apply(m_op, m_q, m_data, sin_l, sin_r);
        m_left--;
        if (m_left == 0) nd = 1;
      end
    end else if (start) begin
      if (count == 0) nd = 1;
      else begin m_left = count; m_op = mode; m_data = d; end
    end else if (en) begin
      m_q = apply(mode, m_q, d, sin_l, sin_r);
    end
    m_done = nd;
  endtask

  task automatic cycle(input bit e, input int md, input int dd, input bit sl, input bit sr,
                       input bit st, input int cnt, input bit c);
    exp_t x;
    en = e; mode = md[2:0]; d = dd[W-1:0]; sin_l = sl; sin_r = sr;
    start = st; count = cnt[CW-1:0]; clr = c;
    model_step();
    x.q = m_q; x.busy = (m_left > 0); x.done = m_done;
    @(posedge clk);
    sb_q.push_back(x);
    #1;
    if (done) done_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(posedge clk) begin
    #2;
    if (mon_en && sb_q.size() > 0) begin
      exp_t x;
      x = sb_q.pop_front();
      chk("q", q, x.q);
      chk("busy", busy, x.busy);
      chk("done", done, x.done);
      chk("sout_l", sout_l, (x.q / 128) % 2);
      chk("sout_r", sout_r, x.q % 2);
      chk("done_not_busy", done && busy, 0);
    end
  end

  initial begin
    int dn;
    #2;
    chk("reset_q", q, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    #10 rst = 0;
    mon_en = 1;

    // async reset mid-cycle
    cycle(1, 1, 'h3C, 0, 0, 0, 0, 0);
    chk("pre_rst_q", q, 'h3C);
    #2 rst = 1;
    #1;
    chk("async_rst_q", q, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    m_q = 0; m_left = 0; m_done = 0;
    #1 rst = 0;

    // single steps
    cycle(1, 1, 'hA5, 0, 0, 0, 0, 0);
    cycle(1, 2, 0, 0, 1, 0, 0, 0);
    chk("shl", q, 'h4B);
    chk("shl_sout_l", sout_l, 0);
    cycle(1, 1, 'hA5, 0, 0, 0, 0, 0);
    cycle(1, 3, 0, 0, 0, 0, 0, 0);
    chk("shr", q, 'h52);
    cycle(1, 1, 'h96, 0, 0, 0, 0, 0);
    cycle(1, 6, 0, 0, 0, 0, 0, 0);
    chk("ashr", q, 'hCB);

    // rotl burst of 3
    cycle(1, 1, 'hA5, 0, 0, 0, 0, 0);
    dn = done_seen;
    cycle(1, 4, 0, 0, 0, 1, 3, 0);
    chk("burst_accept_q", q, 'hA5);
    cycle(1, 0, 0, 0, 0, 0, 0, 0); chk("burst_s1", q, 'h4B);
    cycle(1, 0, 0, 0, 0, 0, 0, 0); chk("burst_s2", q, 'h96);
    cycle(1, 0, 0, 0, 0, 0, 0, 0); chk("burst_s3", q, 'h2D);
    chk("burst_done", done, 1);
    idle(1);
    chk("burst_done_cnt", done_seen - dn, 1);

    // stalled burst
    cycle(1, 1, 'hA5, 0, 0, 0, 0, 0);
    dn = done_seen;
    cycle(1, 4, 0, 0, 0, 1, 3, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0); chk("stall1", q, 'h4B);
    cycle(0, 0, 0, 0, 0, 0, 0, 0); chk("stall2", q, 'h4B);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0); chk("stall_final", q, 'h2D);
    idle(2);
    chk("stall_done_cnt", done_seen - dn, 1);

    // clr aborts a burst
    cycle(1, 1, 'h81, 0, 0, 0, 0, 0);
    dn = done_seen;
    cycle(1, 5, 0, 0, 0, 1, 8, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 1);
    chk("clr_q", q, 0);
    chk("clr_busy", busy, 0);
    idle(10);
    chk("clr_no_done", done_seen - dn, 0);

    // start during a burst is ignored
    cycle(1, 1, 'h81, 0, 0, 0, 0, 0);
    dn = done_seen;
    cycle(1, 5, 0, 0, 0, 1, 4, 0);
    cycle(1, 2, 'hFF, 0, 1, 1, 8, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 0, 0, 0);
    chk("ign_q", q, 'h18);
    idle(10);
    chk("ign_done_cnt", done_seen - dn, 1);

    // zero count, then back-to-back start in the done cycle
    cycle(1, 1, 'h3A, 0, 0, 0, 0, 0);
    cycle(1, 4, 0, 0, 0, 1, 0, 0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_q", q, 'h3A);
    cycle(1, 4, 0, 0, 0, 1, 8, 0);
    chk("b2b_busy", busy, 1);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 0, 0, 0, 0, 0);
    chk("b2b_q", q, 'h3A);
    chk("b2b_done", done, 1);

    // random traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 255),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 4) == 0,
            $urandom_range(0, 8), $urandom_range(0, 29) == 0);

    #2;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
